// File: rtl/tick_period_meter.sv
// Tick period meter: measures spacing of a clock-enable tick stream and recovers the divider value.
// Optional min/max tracking is enabled by defining TICK_METER_MINMAX_EN.
module tick_period_meter #(
  parameter int WIDTH      = 32,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] timeout_value,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  output logic             timeout,
  output logic             locked
`ifdef TICK_METER_MINMAX_EN
  ,
  output logic [WIDTH-1:0] period_min,
  output logic [WIDTH-1:0] period_max,
  input  logic             minmax_clr
`endif
);

  localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    MATCH_ONE  = MW'(1'b1);
  localparam logic [MW-1:0]    MATCH_LOCK = MW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] period_r;
  logic             valid_r;
  logic             overrun_r;
  logic             timeout_r;
  logic             locked_r;
  logic [MW-1:0]    match_r;
  logic [MW-1:0]    match_next_s;
  logic             capture_s;

  assign capture_s = en && (state_r == MEAS) && tick_in;

  // Match count after a capture; period_r still holds the previous capture here.
  always_comb begin
    match_next_s = match_r;
    if ((match_r == {MW{1'b0}}) || (count_r != period_r)) begin
      match_next_s = MATCH_ONE;
    end else if (match_r < MATCH_LOCK) begin
      match_next_s = match_r + MATCH_ONE;
    end else begin
      match_next_s = match_r;
    end
  end

  // Measurement FSM with result register, handshake, timeout and lock tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= {WIDTH{1'b0}};
      period_r  <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
      locked_r  <= 1'b0;
      match_r   <= {MW{1'b0}};
    end else begin
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
      if (valid_r && period_ready) begin
        valid_r <= 1'b0;
      end
      if (!en) begin
        state_r  <= IDLE;
        count_r  <= {WIDTH{1'b0}};
        locked_r <= 1'b0;
        match_r  <= {MW{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= ARM;
          end
          ARM: begin
            if (tick_in) begin
              state_r <= MEAS;
              count_r <= {WIDTH{1'b0}};
            end
          end
          MEAS: begin
            if (tick_in) begin
              // A tick on the timeout cycle still counts as a valid capture.
              period_r  <= count_r;
              valid_r   <= 1'b1;
              overrun_r <= valid_r && !period_ready;
              count_r   <= {WIDTH{1'b0}};
              match_r   <= match_next_s;
              locked_r  <= (match_next_s >= MATCH_LOCK);
            end else if (count_r == timeout_value) begin
              timeout_r <= 1'b1;
              locked_r  <= 1'b0;
              match_r   <= {MW{1'b0}};
              count_r   <= {WIDTH{1'b0}};
              state_r   <= ARM;
            end else begin
              count_r <= count_r + COUNT_ONE;
            end
          end
          default: begin
            state_r <= IDLE;
            count_r <= {WIDTH{1'b0}};
          end
        endcase
      end
    end
  end

  assign period       = period_r;
  assign period_valid = valid_r;
  assign overrun      = overrun_r;
  assign timeout      = timeout_r;
  assign locked       = locked_r;

`ifdef TICK_METER_MINMAX_EN
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;

  // Running extremes of captured periods; a clear coinciding with a capture seeds both.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_r <= {WIDTH{1'b1}};
      max_r <= {WIDTH{1'b0}};
    end else if (minmax_clr) begin
      if (capture_s) begin
        min_r <= count_r;
        max_r <= count_r;
      end else begin
        min_r <= {WIDTH{1'b1}};
        max_r <= {WIDTH{1'b0}};
      end
    end else if (capture_s) begin
      if (count_r < min_r) begin
        min_r <= count_r;
      end
      if (count_r > max_r) begin
        max_r <= count_r;
      end
    end
  end

  assign period_min = min_r;
  assign period_max = max_r;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed self-checking bench for tick_period_meter (WIDTH=32, LOCK_COUNT=2).
// Min/max checks are included when TICK_METER_MINMAX_EN is defined.
module tb_tick_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        tick_in;
  logic [31:0] timeout_value;
  logic [31:0] period;
  logic        period_valid;
  logic        period_ready;
  logic        overrun;
  logic        timeout;
  logic        locked;
`ifdef TICK_METER_MINMAX_EN
  logic [31:0] period_min;
  logic [31:0] period_max;
  logic        minmax_clr;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  tick_period_meter #(.WIDTH(32), .LOCK_COUNT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .tick_in(tick_in), .timeout_value(timeout_value),
    .period(period), .period_valid(period_valid), .period_ready(period_ready),
    .overrun(overrun), .timeout(timeout), .locked(locked)
`ifdef TICK_METER_MINMAX_EN
    , .period_min(period_min), .period_max(period_max), .minmax_clr(minmax_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom); tick_in = 1'($urandom); period_ready = 1'($urandom);
      timeout_value = $urandom;
      step();
    end
    total_cnt++; if (period !== 32'd0) $display("FAIL reset_period actual=%0d expected=0", period); else pass_cnt++;
    total_cnt++; if (period_valid !== 1'b0) $display("FAIL reset_valid actual=%b expected=0", period_valid); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun actual=%b expected=0", overrun); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL reset_timeout actual=%b expected=0", timeout); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked actual=%b expected=0", locked); else pass_cnt++;
`ifdef TICK_METER_MINMAX_EN
    total_cnt++; if (period_min !== 32'hFFFF_FFFF) $display("FAIL reset_min actual=%h expected=ffffffff", period_min); else pass_cnt++;
    total_cnt++; if (period_max !== 32'd0) $display("FAIL reset_max actual=%0d expected=0", period_max); else pass_cnt++;
`endif
    rst = 1'b0; en = 1'b0; tick_in = 1'b1; period_ready = 1'b1; timeout_value = 32'd100;
    step();
    step();
    tick_in = 1'b0;
    total_cnt++; if (period_valid !== 1'b0) $display("FAIL idle_no_result actual=%b expected=0", period_valid); else pass_cnt++;
  endtask

  task automatic test_steady();
    en = 1'b1;
    step();
    for (int cyc = 0; cyc <= 23; cyc++) begin
      tick_in = ((cyc % 5) == 0) || (cyc == 23);
      step();
      if (cyc == 5) begin
        total_cnt++; if (period !== 32'd4 || period_valid !== 1'b1) $display("FAIL steady_first actual=%0d/%b expected=4/1", period, period_valid); else pass_cnt++;
        total_cnt++; if (locked !== 1'b0) $display("FAIL steady_unlocked actual=%b expected=0", locked); else pass_cnt++;
      end
      if (cyc == 6) begin
        total_cnt++; if (period_valid !== 1'b0) $display("FAIL steady_consumed actual=%b expected=0", period_valid); else pass_cnt++;
      end
      if (cyc == 10 || cyc == 20) begin
        total_cnt++; if (period !== 32'd4 || locked !== 1'b1) $display("FAIL steady_locked cyc=%0d actual=%0d/%b expected=4/1", cyc, period, locked); else pass_cnt++;
      end
      if (cyc == 23) begin
        total_cnt++; if (period !== 32'd2 || locked !== 1'b0) $display("FAIL steady_change actual=%0d/%b expected=2/0", period, locked); else pass_cnt++;
      end
    end
    tick_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    tick_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin
        total_cnt++; if (period_valid !== 1'b0) $display("FAIL b2b_arm_no_result actual=%b expected=0", period_valid); else pass_cnt++;
      end else begin
        total_cnt++; if (period !== 32'd0 || period_valid !== 1'b1 || timeout !== 1'b0) $display("FAIL b2b_result i=%0d actual=%0d/%b/%b expected=0/1/0", i, period, period_valid, timeout); else pass_cnt++;
      end
      if (i == 1) begin
        total_cnt++; if (locked !== 1'b0) $display("FAIL b2b_first_unlocked actual=%b expected=0", locked); else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++; if (locked !== 1'b1) $display("FAIL b2b_locked actual=%b expected=1", locked); else pass_cnt++;
      end
    end
    tick_in = 1'b0;
    step();
    total_cnt++; if (period_valid !== 1'b0 || timeout !== 1'b0) $display("FAIL b2b_drain actual=%b/%b expected=0/0", period_valid, timeout); else pass_cnt++;
  endtask

  task automatic test_timeout();
    timeout_value = 32'd10;
    for (int k = 1; k <= 9; k++) begin
      step();
      total_cnt++; if (timeout !== 1'b0) $display("FAIL to_early k=%0d actual=%b expected=0", k, timeout); else pass_cnt++;
    end
    step();
    total_cnt++; if (timeout !== 1'b1 || locked !== 1'b0) $display("FAIL to_pulse actual=%b/%b expected=1/0", timeout, locked); else pass_cnt++;
    step();
    total_cnt++; if (timeout !== 1'b0) $display("FAIL to_one_cycle actual=%b expected=0", timeout); else pass_cnt++;
    tick_in = 1'b1;
    step();
    total_cnt++; if (period_valid !== 1'b0) $display("FAIL to_rearm_no_result actual=%b expected=0", period_valid); else pass_cnt++;
    tick_in = 1'b0;
    for (int k = 0; k < 10; k++) step();
    total_cnt++; if (timeout !== 1'b0) $display("FAIL to_before_edge actual=%b expected=0", timeout); else pass_cnt++;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    total_cnt++; if (period !== 32'd10 || period_valid !== 1'b1 || timeout !== 1'b0) $display("FAIL to_tick_wins actual=%0d/%b/%b expected=10/1/0", period, period_valid, timeout); else pass_cnt++;
  endtask

  task automatic test_handshake();
    timeout_value = 32'd100;
    en = 1'b0;
    step();
    en = 1'b1; period_ready = 1'b0;
    step();
    for (int cyc = 0; cyc <= 10; cyc++) begin
      tick_in = ((cyc % 3) == 0);
      period_ready = (cyc >= 9);
      step();
      if (cyc == 3) begin
        total_cnt++; if (period !== 32'd2 || period_valid !== 1'b1 || overrun !== 1'b0) $display("FAIL hs_first actual=%0d/%b/%b expected=2/1/0", period, period_valid, overrun); else pass_cnt++;
      end
      if (cyc == 4 || cyc == 7) begin
        total_cnt++; if (period_valid !== 1'b1 || overrun !== 1'b0) $display("FAIL hs_hold cyc=%0d actual=%b/%b expected=1/0", cyc, period_valid, overrun); else pass_cnt++;
      end
      if (cyc == 6) begin
        total_cnt++; if (period !== 32'd2 || overrun !== 1'b1) $display("FAIL hs_overrun actual=%0d/%b expected=2/1", period, overrun); else pass_cnt++;
      end
      if (cyc == 9) begin
        total_cnt++; if (period_valid !== 1'b1 || overrun !== 1'b0 || period !== 32'd2) $display("FAIL hs_concurrent actual=%b/%b/%0d expected=1/0/2", period_valid, overrun, period); else pass_cnt++;
      end
      if (cyc == 10) begin
        total_cnt++; if (period_valid !== 1'b0) $display("FAIL hs_drained actual=%b expected=0", period_valid); else pass_cnt++;
      end
    end
    tick_in = 1'b0;
  endtask

`ifdef TICK_METER_MINMAX_EN
  task automatic test_minmax();
    period_ready = 1'b1;
    minmax_clr = 1'b1;
    step();
    minmax_clr = 1'b0;
    total_cnt++; if (period_min !== 32'hFFFF_FFFF || period_max !== 32'd0) $display("FAIL mm_clear0 actual=%h/%0d expected=ffffffff/0", period_min, period_max); else pass_cnt++;
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    for (int cyc = 0; cyc <= 22; cyc++) begin
      tick_in = (cyc == 0) || (cyc == 8) || (cyc == 12) || (cyc == 22);
      step();
    end
    tick_in = 1'b0;
    total_cnt++; if (period_min !== 32'd3 || period_max !== 32'd9) $display("FAIL mm_track actual=%0d/%0d expected=3/9", period_min, period_max); else pass_cnt++;
    minmax_clr = 1'b1;
    step();
    total_cnt++; if (period_min !== 32'hFFFF_FFFF || period_max !== 32'd0) $display("FAIL mm_clear actual=%h/%0d expected=ffffffff/0", period_min, period_max); else pass_cnt++;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0; minmax_clr = 1'b0;
    total_cnt++; if (period_min !== 32'd1 || period_max !== 32'd1) $display("FAIL mm_clear_capture actual=%0d/%0d expected=1/1", period_min, period_max); else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; tick_in = 1'b0; period_ready = 1'b0; timeout_value = 32'd0;
`ifdef TICK_METER_MINMAX_EN
    minmax_clr = 1'b0;
`endif
    test_reset();
    test_steady();
    test_back_to_back();
    test_timeout();
    test_handshake();
`ifdef TICK_METER_MINMAX_EN
    test_minmax();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
